// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the MEM-stage 32-bit to 16-bit async SRAM controller:
// state encodings, bus widths, default base address and the address-map helper.
package sram_ctrl_pkg;

  localparam int unsigned SRAM_AW       = 18;
  localparam int unsigned SRAM_DW       = 16;
  localparam int unsigned WORD_W        = 17;
  localparam int unsigned DEF_BASE_ADDR = 1024;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACC_LO = 2'd1,
    ST_ACC_HI = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // 32-bit word index inside the SRAM window; the subtraction wraps modulo 2^32
  // so addresses just below the base land at the top of the SRAM.
  function automatic logic [WORD_W-1:0] word_of(input logic [31:0] addr,
                                               input logic [31:0] base);
    return WORD_W'((addr - base) >> 2);
  endfunction

endpackage

// File: rtl/sram_controller.sv
// Splits each 32-bit load/store into two 16-bit async SRAM accesses (low half
// first) with a fixed wait-state count; ready low freezes the pipeline.
module sram_controller
  import sram_ctrl_pkg::*;
#(
  parameter int          ACCESS_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR     = DEF_BASE_ADDR
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic                 rd_en,
  input  logic [31:0]          address,
  input  logic [31:0]          write_data,
  output logic [31:0]          read_data,
  output logic                 ready,
  inout  wire  [SRAM_DW-1:0]   SRAM_DQ,
  output logic [SRAM_AW-1:0]   SRAM_ADDR,
  output logic                 SRAM_WE_N,
  output logic                 SRAM_OE_N,
  output logic                 SRAM_CE_N,
  output logic                 SRAM_UB_N,
  output logic                 SRAM_LB_N,
  output logic [1:0]           dbg_state_o
);

  localparam int             CNT_W    = $clog2(ACCESS_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                wr_op_q, wr_op_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         rdata_q, rdata_d;

  logic                req;
  logic                last;
  logic                in_acc;
  logic                dq_drive;
  logic [SRAM_DW-1:0]  dq_out;

  assign req  = wr_en | rd_en;
  assign last = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      wr_op_q <= 1'b0;
      word_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_op_q <= wr_op_d;
      word_q  <= word_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Next state; read halves are captured on the final wait-state cycle of each
  // phase, when the SRAM output has had the full access time to settle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_op_d = wr_op_q;
    word_d  = word_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          wr_op_d = wr_en;
          word_d  = word_of(address, BASE_ADDR);
          wdata_d = write_data;
          cnt_d   = '0;
          state_d = ST_ACC_LO;
        end
      end
      ST_ACC_LO: begin
        if (last) begin
          cnt_d   = '0;
          state_d = ST_ACC_HI;
          if (!wr_op_q) rdata_d[15:0] = SRAM_DQ;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_ACC_HI: begin
        if (last) begin
          cnt_d   = '0;
          state_d = ST_DONE;
          if (!wr_op_q) rdata_d[31:16] = SRAM_DQ;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobes decode straight from the registered state, so an async reset
  // releases the bus without waiting for a clock edge.
  always_comb begin
    in_acc    = (state_q == ST_ACC_LO) || (state_q == ST_ACC_HI);
    SRAM_CE_N = !in_acc;
    SRAM_WE_N = !(in_acc && wr_op_q);
    SRAM_OE_N = !(in_acc && !wr_op_q);
    SRAM_ADDR = '0;
    if (in_acc) SRAM_ADDR = {word_q, (state_q == ST_ACC_HI)};
    dq_drive  = in_acc && wr_op_q;
    dq_out    = (state_q == ST_ACC_HI) ? wdata_q[31:16] : wdata_q[15:0];
    ready     = ((state_q == ST_IDLE) && !req) || (state_q == ST_DONE);
  end

  assign SRAM_DQ     = dq_drive ? dq_out : {SRAM_DW{1'bz}};
  assign SRAM_UB_N   = 1'b0;
  assign SRAM_LB_N   = 1'b0;
  assign read_data   = rdata_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: instance A (2 wait states) and instance B
// (1 wait state), each with a behavioral async SRAM and cycle-exact checks.
module tb_sram_controller;

  logic        clk;
  logic        rst;

  logic        a_wr_en, a_rd_en, b_wr_en, b_rd_en;
  logic [31:0] a_address, a_write_data, b_address, b_write_data;
  logic [31:0] a_read_data, b_read_data;
  logic        a_ready, b_ready;
  wire  [15:0] a_dq, b_dq;
  logic [17:0] a_addr, b_addr;
  logic        a_we_n, a_oe_n, a_ce_n, a_ub_n, a_lb_n;
  logic        b_we_n, b_oe_n, b_ce_n, b_ub_n, b_lb_n;
  logic [1:0]  a_state, b_state;

  int          n_checks = 0;
  int          n_bad    = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_a = 32'h0;
  logic [31:0] last_b = 32'h0;
  logic [15:0] ref_mem_a [int];
  logic [15:0] ref_mem_b [int];
  logic [15:0] mem_a [0:262143];
  logic [15:0] mem_b [0:262143];

  sram_controller #(.ACCESS_CYCLES(2), .BASE_ADDR(32'd1024)) dut_a (
    .clk(clk), .rst(rst), .wr_en(a_wr_en), .rd_en(a_rd_en),
    .address(a_address), .write_data(a_write_data), .read_data(a_read_data),
    .ready(a_ready), .SRAM_DQ(a_dq), .SRAM_ADDR(a_addr), .SRAM_WE_N(a_we_n),
    .SRAM_OE_N(a_oe_n), .SRAM_CE_N(a_ce_n), .SRAM_UB_N(a_ub_n),
    .SRAM_LB_N(a_lb_n), .dbg_state_o(a_state)
  );

  sram_controller #(.ACCESS_CYCLES(1), .BASE_ADDR(32'd1024)) dut_b (
    .clk(clk), .rst(rst), .wr_en(b_wr_en), .rd_en(b_rd_en),
    .address(b_address), .write_data(b_write_data), .read_data(b_read_data),
    .ready(b_ready), .SRAM_DQ(b_dq), .SRAM_ADDR(b_addr), .SRAM_WE_N(b_we_n),
    .SRAM_OE_N(b_oe_n), .SRAM_CE_N(b_ce_n), .SRAM_UB_N(b_ub_n),
    .SRAM_LB_N(b_lb_n), .dbg_state_o(b_state)
  );

  // Behavioral async SRAMs: drive on OE read, capture on WE low.
  assign a_dq = (!a_ce_n && !a_oe_n && a_we_n) ? mem_a[a_addr] : 16'hzzzz;
  assign b_dq = (!b_ce_n && !b_oe_n && b_we_n) ? mem_b[b_addr] : 16'hzzzz;
  always @(posedge clk) if (!a_ce_n && !a_we_n) mem_a[a_addr] <= a_dq;
  always @(posedge clk) if (!b_ce_n && !b_we_n) mem_b[b_addr] <= b_dq;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input bit sel);
    string p;
    p = sel ? "b" : "a";
    check({p, "_rst_ready"}, sel ? b_ready : a_ready, 32'd1);
    check({p, "_rst_we_n"},  sel ? b_we_n : a_we_n, 32'd1);
    check({p, "_rst_oe_n"},  sel ? b_oe_n : a_oe_n, 32'd1);
    check({p, "_rst_ce_n"},  sel ? b_ce_n : a_ce_n, 32'd1);
    check({p, "_rst_addr"},  sel ? b_addr : a_addr, 32'd0);
    check({p, "_rst_dq"},    sel ? b_dq : a_dq, 16'hzzzz);
    check({p, "_rst_rdata"}, sel ? b_read_data : a_read_data, 32'd0);
    check({p, "_rst_state"}, sel ? b_state : a_state, 32'd0);
  endtask

  // driver: one access, entered just after a rising edge (cycle 0), left just
  // after the edge ending DONE so a follow-on access can start back-to-back.
  task automatic do_access(input bit sel, input bit wr, input bit rd,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int n);
    logic [31:0] off;
    logic [16:0] w;
    logic [17:0] exp_addr;
    logic [15:0] exp_dq;
    logic [31:0] v;
    bit          lo, hi, acc;
    off = addr - 32'd1024;
    w   = off[18:2];
    if (sel) begin
      b_wr_en = wr; b_rd_en = rd; b_address = addr; b_write_data = wdata;
    end else begin
      a_wr_en = wr; a_rd_en = rd; a_address = addr; a_write_data = wdata;
    end
    if (wr) begin
      if (sel) begin
        ref_mem_b[{w, 1'b0}] = wdata[15:0]; ref_mem_b[{w, 1'b1}] = wdata[31:16];
        exp_q.push_back(last_b);
      end else begin
        ref_mem_a[{w, 1'b0}] = wdata[15:0]; ref_mem_a[{w, 1'b1}] = wdata[31:16];
        exp_q.push_back(last_a);
      end
    end else begin
      if (sel) begin
        v = {ref_mem_b[{w, 1'b1}], ref_mem_b[{w, 1'b0}]}; last_b = v;
      end else begin
        v = {ref_mem_a[{w, 1'b1}], ref_mem_a[{w, 1'b0}]}; last_a = v;
      end
      exp_q.push_back(v);
    end
    for (int c = 0; c <= 2 * n + 1; c++) begin
      @(negedge clk);
      lo  = (c >= 1) && (c <= n);
      hi  = (c > n) && (c <= 2 * n);
      acc = lo || hi;
      exp_addr = lo ? {w, 1'b0} : (hi ? {w, 1'b1} : 18'd0);
      if (acc && wr)      exp_dq = hi ? wdata[31:16] : wdata[15:0];
      else if (acc)       exp_dq = sel ? ref_mem_b[exp_addr] : ref_mem_a[exp_addr];
      else                exp_dq = 16'hzzzz;
      check($sformatf("ready c%0d", c), sel ? b_ready : a_ready, (c == 2 * n + 1) ? 32'd1 : 32'd0);
      check($sformatf("addr c%0d", c),  sel ? b_addr : a_addr, exp_addr);
      check($sformatf("ce_n c%0d", c),  sel ? b_ce_n : a_ce_n, acc ? 32'd0 : 32'd1);
      check($sformatf("we_n c%0d", c),  sel ? b_we_n : a_we_n, (acc && wr) ? 32'd0 : 32'd1);
      check($sformatf("oe_n c%0d", c),  sel ? b_oe_n : a_oe_n, (acc && !wr) ? 32'd0 : 32'd1);
      check($sformatf("dq c%0d", c),    sel ? b_dq : a_dq, exp_dq);
      if (c == 2 * n + 1) begin
        if (exp_q.size() == 0) check("sb_empty", 32'd1, 32'd0);
        else check("rdata", sel ? b_read_data : a_read_data, exp_q.pop_front());
        check("done_state", sel ? b_state : a_state, 32'd3);
      end
      @(posedge clk);
      #1;
    end
    if (sel) begin b_wr_en = 1'b0; b_rd_en = 1'b0; end
    else begin a_wr_en = 1'b0; a_rd_en = 1'b0; end
  endtask

  initial begin
    rst = 1'b0;
    a_wr_en = 0; a_rd_en = 0; a_address = 0; a_write_data = 0;
    b_wr_en = 0; b_rd_en = 0; b_address = 0; b_write_data = 0;
    for (int i = 0; i < 1024; i++) begin
      mem_a[i] = 16'(i * 37) ^ 16'h5a5a;
      ref_mem_a[i] = mem_a[i];
    end
    mem_a[2] = 16'h5678; ref_mem_a[2] = 16'h5678;
    mem_a[3] = 16'h1234; ref_mem_a[3] = 16'h1234;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs(1'b0);
    check_reset_outputs(1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;

    do_access(1'b0, 1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, 2);
    do_access(1'b0, 1'b0, 1'b1, 32'd1028, 32'h0, 2);
    check("rd_1028", a_read_data, 32'hDEADBEEF);
    // back-to-back: write then immediate read of the same word
    do_access(1'b0, 1'b1, 1'b0, 32'd1036, 32'hCAFEF00D, 2);
    do_access(1'b0, 1'b0, 1'b1, 32'd1036, 32'h0, 2);
    // simultaneous request: write wins, read_data keeps CAFEF00D
    do_access(1'b0, 1'b1, 1'b1, 32'd1040, 32'hA5A55A5A, 2);
    do_access(1'b0, 1'b0, 1'b1, 32'd1040, 32'h0, 2);
    for (int k = 0; k < 6; k++) begin
      logic [31:0] ra;
      bit          rw;
      ra = 32'd1024 + 32'(4 * $urandom_range(4, 200)) + 32'($urandom_range(0, 3));
      rw = 1'($urandom_range(0, 1));
      do_access(1'b0, rw, !rw, ra, $urandom, 2);
    end

    // async reset while in ACC_HI of a write
    a_wr_en = 1'b1; a_address = 32'd1200; a_write_data = 32'h11112222;
    repeat (3) begin @(posedge clk); #1; end
    check("pre_rst_state", a_state, 32'd2);
    #2;
    rst = 1'b0; a_wr_en = 1'b0;
    #1;
    check_reset_outputs(1'b0);
    last_a = 32'h0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // one wait state, address below base wraps to the top word
    do_access(1'b1, 1'b1, 1'b0, 32'd1020, 32'h0BADF00D, 1);
    do_access(1'b1, 1'b0, 1'b1, 32'd1020, 32'h0, 1);
    check("b_rd_wrap", b_read_data, 32'h0BADF00D);
    do_access(1'b0, 1'b0, 1'b1, 32'd1028, 32'h0, 2);

    check("sb_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_controller.md
# sram_controller

Memory-stage controller bridging the pipeline's 32-bit data-memory requests to a 16-bit external asynchronous SRAM. It sits in the MEM stage, directly upstream of the MEM/WB pipeline register. It supplies that register's memory-read value, and its `ready` is inverted to form the pipeline `freeze`. Each 32-bit access is split into two 16-bit half-word cycles, each with a fixed wait-state count.

## Interface
- `ACCESS_CYCLES`, default 2: clock cycles per half-word access (must be ≥1).
- `BASE_ADDR`, default 1024: data-memory byte address mapped to SRAM word 0.
- `clk`  in  1: pipeline clock, all state updates on rising edge.
- `rst`  in  1: one clock; reset is asynchronous and active-low.
- `wr_en`  in  1: store request, held stable by the frozen pipeline.
- `rd_en`  in  1: load request, held stable by the frozen pipeline.
- `address`  in  32: byte address (ALU result).
- `write_data`  in  32: store data.
- `read_data`  out  32: assembled load data, valid while `ready`=1 in DONE.
- `ready`  out  1: 0 while an access is outstanding; pipeline freeze = ~ready.
- `SRAM_DQ`  inout  16: SRAM data bus.
- `SRAM_ADDR`  out  18: SRAM half-word address.
- `SRAM_WE_N`, `SRAM_OE_N`, `SRAM_CE_N`, `SRAM_UB_N`, `SRAM_LB_N`  out  1 each: active-low SRAM strobes.

## Operation
- States: IDLE, ACC_LO, ACC_HI, DONE. A counter `cnt` of width $clog2(ACCESS_CYCLES)+1 tracks the cycles spent in ACC_LO and ACC_HI.
- IDLE, with `wr_en` or `rd_en` asserted: latch op (write wins if both asserted), address and write_data. Clear `cnt`, then go to ACC_LO.
- ACC_LO: when `cnt`=ACCESS_CYCLES-1, go to ACC_HI and clear `cnt`. Otherwise increment `cnt`.
- ACC_HI: the same counting rule applies, then go to DONE.
- DONE: go to IDLE unconditionally after one cycle. A request seen in the following IDLE cycle is a new instruction.
- Address map: word = (address - BASE_ADDR)[18:2], using 32-bit modulo subtraction. SRAM_ADDR = {word,1'b0} in ACC_LO and {word,1'b1} in ACC_HI. Bits [1:0] are ignored.
- Writes drive SRAM_DQ with write_data[15:0] in ACC_LO and write_data[31:16] in ACC_HI. SRAM_WE_N=0 throughout both states.
- Reads drive SRAM_OE_N=0 in ACC_LO/ACC_HI. SRAM_DQ is sampled on the last cycle of ACC_LO into read_data[15:0], and on the last cycle of ACC_HI into read_data[31:16].
- SRAM_DQ is high-Z except during write ACC_LO/ACC_HI.
- SRAM_CE_N=0 only in ACC_LO/ACC_HI. UB_N and LB_N are tied 0.
- `ready` is combinational:
  - 1 in IDLE with no request;
  - 1 in DONE;
  - 0 otherwise, including the IDLE cycle in which a request first appears.

## Timing
- Reset values: state IDLE, `cnt` 0, read_data 0, ready 1, SRAM_WE_N/OE_N/CE_N 1, SRAM_ADDR 0, SRAM_DQ high-Z.
- Request first visible at cycle 0. ACC_LO covers cycles 1..N, ACC_HI covers N+1..2N, and DONE is cycle 2N+1 (N=ACCESS_CYCLES).
- `ready` is low for 2N+1 cycles. With the default N=2, ready is low in cycles 0–4, high in cycle 5, and the pipeline advances on the edge ending cycle 5.
- read_data holds its value until the next read's samples overwrite it. Writes do not alter read_data.
- Reset mid-access: the access is aborted immediately (asynchronously), the bus is released, and the state returns to IDLE. A partial write to the SRAM is permitted.
- Back-to-back accesses: the next access starts at the earliest in the IDLE cycle following DONE. There is no pipelining of accesses.

## Structure
- Shared package/header `sram_ctrl_pkg`: state encodings (IDLE=0, ACC_LO=1, ACC_HI=2, DONE=3), default BASE_ADDR, SRAM address/data widths.
- Single module with no sub-modules. The tri-state driver is a continuous assign inside the module.

## Test plan
- Reset: assert rst=0 mid-state. Required: all outputs return to their reset values immediately, SRAM_DQ is high-Z, and ready=1.
- Write: address=1028, write_data=0xDEADBEEF, N=2. Required:
  - SRAM_ADDR=2 with DQ=0xBEEF in cycles 1–2;
  - SRAM_ADDR=3 with DQ=0xDEAD in cycles 3–4;
  - WE_N=0 throughout cycles 1–4;
  - ready=0 in cycles 0–4 and 1 in cycle 5.
- Read: SRAM model holds word 2 = 0x5678 and word 3 = 0x1234; address=1028. Required: read_data=0x12345678 with ready=1 in cycle 5, OE_N=0 in cycles 1–4, and DQ never driven.
- Back-to-back: a read follows immediately after a write. Required: the second access begins in the IDLE cycle after DONE, ready pulses high for exactly one cycle between the accesses, and the data is correct.
- Simultaneous wr_en=rd_en=1. Required: a write is performed and read_data is unchanged.
- Parameter sweep with ACCESS_CYCLES=1. Required: ready is low for 3 cycles and high in cycle 3, and address wrap holds (address=1020 maps to word 0x1FFFF).
